axil_config_bank: RTL

Parametrised AXI4-Lite configuration/status register bank, the successor to the fixed-map per-core control blocks. It provides NUM_RW double-buffered read/write configuration words (shadow → active on commit), NUM_RO read-only status words, byte-strobe writes and an interlock (cfg_lock) that defers commits while the consuming core is busy. It contains its own AXI4-Lite slave logic, with one outstanding transaction per direction.

---
 rtl/axil_config_bank_if.sv | 35 +++
 rtl/axil_config_bank.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/axil_config_bank_if.sv
// AXI4-Lite slave bus bundle for the configuration register bank.
// Master drives the request channels and the response ready signals.
interface axil_config_bank_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [2:0]  awprot;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [2:0]  arprot;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    output araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wstrb, wvalid, bready,
    input  araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_config_bank.sv
// AXI4-Lite register bank: double-buffered RW config words committed shadow->active,
// RO status words, and a CTRL word with COMMIT/AUTO and a cfg_lock commit interlock.
module axil_config_bank #(
  parameter int                   NUM_RW    = 13,
  parameter int                   NUM_RO    = 4,
  parameter logic [NUM_RW*32-1:0] RESET_VAL = '0
) (
  input  logic                                    clk,
  input  logic                                    resetn,
  axil_config_bank_if.slave                       s_axi,
  output logic [NUM_RW*32-1:0]                    cfg_out,
  output logic                                    cfg_update,
  input  logic                                    cfg_lock,
  input  logic [((NUM_RO > 0) ? NUM_RO : 1)*32-1:0] status_in
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [4:0] CTRL_IDX    = 5'd31;

  typedef enum logic [1:0] {REG_RW, REG_RO, REG_CTRL, REG_NONE} reg_kind_t;

  function automatic reg_kind_t decode(input logic [4:0] idx);
    if (idx == CTRL_IDX) return REG_CTRL;
    if (int'(idx) < NUM_RW) return REG_RW;
    if (int'(idx) >= 16 && int'(idx) < 16 + NUM_RO) return REG_RO;
    return REG_NONE;
  endfunction

  logic              aw_full_reg, w_full_reg, bvalid_reg;
  logic [4:0]        aw_idx_reg;
  logic [31:0]       w_data_reg;
  logic [3:0]        w_strb_reg;
  logic [1:0]        bresp_reg;
  logic              pending_reg, pending_next;
  logic              auto_reg, auto_next;
  logic              cfg_update_reg;
  logic              rvalid_reg;
  logic [31:0]       rdata_reg, rd_data;
  logic [1:0]        rresp_reg, rd_resp, wr_resp;
  logic [NUM_RW*32-1:0] shadow_flat;
  logic [4:0]        ar_idx;
  logic              wr_fire, commit;
  reg_kind_t         wr_kind;
  logic              unused_bits;

  assign wr_fire = aw_full_reg & w_full_reg & ~bvalid_reg;
  assign wr_kind = decode(aw_idx_reg);
  assign commit  = pending_reg & ~cfg_lock;
  assign ar_idx  = s_axi.araddr[6:2];

  assign s_axi.awready = ~aw_full_reg;
  assign s_axi.wready  = ~w_full_reg;
  assign s_axi.bvalid  = bvalid_reg;
  assign s_axi.bresp   = bresp_reg;
  assign s_axi.arready = ~rvalid_reg;
  assign s_axi.rvalid  = rvalid_reg;
  assign s_axi.rdata   = rdata_reg;
  assign s_axi.rresp   = rresp_reg;
  assign cfg_update    = cfg_update_reg;

  assign unused_bits = ^{s_axi.awaddr[31:7], s_axi.awaddr[1:0], s_axi.araddr[31:7],
                         s_axi.araddr[1:0], s_axi.awprot, s_axi.arprot};

  always_comb begin
    case (wr_kind)
      REG_RW, REG_CTRL: wr_resp = RESP_OKAY;
      REG_RO:           wr_resp = RESP_SLVERR;
      default:          wr_resp = RESP_DECERR;
    endcase
  end

  // A write requesting PENDING on a commit edge overrides the clear, forcing a second commit.
  always_comb begin
    pending_next = pending_reg & ~commit;
    auto_next    = auto_reg;
    if (wr_fire) begin
      if (wr_kind == REG_CTRL && w_strb_reg[0]) begin
        auto_next = w_data_reg[1];
        if (w_data_reg[0]) pending_next = 1'b1;
      end
      if (wr_kind == REG_RW && auto_reg) pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      aw_full_reg    <= 1'b0;
      w_full_reg     <= 1'b0;
      bvalid_reg     <= 1'b0;
      aw_idx_reg     <= '0;
      w_data_reg     <= '0;
      w_strb_reg     <= '0;
      bresp_reg      <= RESP_OKAY;
      pending_reg    <= 1'b0;
      auto_reg       <= 1'b0;
      cfg_update_reg <= 1'b0;
    end else begin
      pending_reg    <= pending_next;
      auto_reg       <= auto_next;
      cfg_update_reg <= commit;
      if (bvalid_reg && s_axi.bready) begin
        aw_full_reg <= 1'b0;
        w_full_reg  <= 1'b0;
        bvalid_reg  <= 1'b0;
      end else begin
        if (s_axi.awvalid && !aw_full_reg) begin
          aw_full_reg <= 1'b1;
          aw_idx_reg  <= s_axi.awaddr[6:2];
        end
        if (s_axi.wvalid && !w_full_reg) begin
          w_full_reg <= 1'b1;
          w_data_reg <= s_axi.wdata;
          w_strb_reg <= s_axi.wstrb;
        end
        if (wr_fire) begin
          bvalid_reg <= 1'b1;
          bresp_reg  <= wr_resp;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : gen_word
    logic [31:0] shadow_reg, active_reg;

    // Commit copies the shadow as it stood before any write landing on the same edge.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        shadow_reg <= RESET_VAL[32*gi +: 32];
        active_reg <= RESET_VAL[32*gi +: 32];
      end else begin
        if (commit) active_reg <= shadow_reg;
        if (wr_fire && aw_idx_reg == 5'(gi)) begin
          for (int b = 0; b < 4; b++) begin
            if (w_strb_reg[b]) shadow_reg[8*b +: 8] <= w_data_reg[8*b +: 8];
          end
        end
      end
    end

    assign shadow_flat[32*gi +: 32] = shadow_reg;
    assign cfg_out[32*gi +: 32]     = active_reg;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_DECERR;
    case (decode(ar_idx))
      REG_RW: begin
        rd_resp = RESP_OKAY;
        for (int i = 0; i < NUM_RW; i++) begin
          if (ar_idx == 5'(i)) rd_data = shadow_flat[32*i +: 32];
        end
      end
      REG_RO: begin
        rd_resp = RESP_OKAY;
        for (int j = 0; j < NUM_RO; j++) begin
          if (ar_idx == 5'(16 + j)) rd_data = status_in[32*j +: 32];
        end
      end
      REG_CTRL: begin
        rd_resp = RESP_OKAY;
        rd_data = {30'b0, auto_reg, pending_reg};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_reg <= 1'b0;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else if (s_axi.arvalid && !rvalid_reg) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data;
      rresp_reg  <= rd_resp;
    end else if (rvalid_reg && s_axi.rready) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule
